pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL expose: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: instr_in  in  32  fetched RV32 instruction word.
REQ-004 SHALL expose: instr_valid  in  1  instr_in valid this cycle.
REQ-005 SHALL expose: mul_done  in  1  multi-cycle multiplier result ready (one-cycle pulse).
REQ-006 SHALL expose: stall  out  1  fetch must hold PC and instr_in.
REQ-007 SHALL expose: ex_instr  out  32  instruction in EX stage; ex_valid  out  1  EX occupied.
REQ-008 SHALL expose: mul_start  out  1  one-cycle start pulse to multiplier.
REQ-009 SHALL expose: fwd_rs1 / fwd_rs2  out  1 each  select WB result instead of regfile operand.
REQ-010 SHALL expose: wb_valid  out  1; wb_rd  out  5; wb_regwrite  out  1; gpio_we  out  1; illegal  out  1.

Function
REQ-011 Pipeline SHALL be 3 stages: F (external), EX (ex_instr reg), WB (wb_rd/wb_regwrite regs); one instruction advances per unstalled cycle.
REQ-012 Decode SHALL classify: addi/andi/slli (0010011), add/sub/and/sll/slt (0110011), mul (0110011, funct3 000, funct7 0000001), lui (0110111), csrrw (1110011, funct3 001); anything else is illegal.
REQ-013 wb_regwrite SHALL be 1 for every legal class when rd != 0, else 0.
REQ-014 gpio_we SHALL be 1 exactly in the cycle a valid csrrw occupies WB.
REQ-015 illegal SHALL pulse 1 cycle when an illegal instruction enters EX; it SHALL proceed as a bubble (no regwrite, no gpio_we).
REQ-016 EX FSM states SHALL be RUN and MUL_WAIT; reset state RUN.
REQ-017 RUN -> MUL_WAIT when a valid mul enters EX; mul_start SHALL pulse in the first EX cycle only.
REQ-018 In MUL_WAIT, stall=1, ex_instr held, WB receives bubbles (wb_valid=0); on mul_done, mul advances to WB next edge, state -> RUN, stall deasserts same cycle as mul_done.
REQ-019 mul_done in RUN SHALL be ignored.
REQ-020 Hazard: RAW exists when ex_valid, wb_valid, wb_regwrite, wb_rd != 0 and wb_rd equals EX rs1 (or rs2, for R-type only).
REQ-021 When stall=1, instr_in SHALL NOT be captured; instr_valid=0 inserts bubble into EX.
REQ-022 Simultaneous mul entry and RAW: forwarding/stall of REQ-020/Configuration applied first, then mul_start.

Reset
REQ-023 On rst_n=0 (any cycle, including mid-MUL_WAIT): state RUN, ex_valid=0, wb_valid=0, ex_instr=0, wb_rd=0; all outputs 0 (stall, mul_start, fwd_*, wb_regwrite, gpio_we, illegal).
REQ-024 First instruction SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro PIPE_FWD_EN defined: RAW drives fwd_rs1/fwd_rs2=1 combinationally, no stall.
REQ-026 PIPE_FWD_EN undefined: fwd_* tied 0; RAW holds EX one cycle (stall=1, WB bubble), then proceeds.

Structure
REQ-027 Package pipe_pkg SHALL hold opcode/funct3/funct7 constants, instruction-class enum and EX FSM state enum.
REQ-028 Combinational RAW comparison SHALL live in sub-module pipe_hazard (inputs: ex rs1/rs2/class, wb_rd/wb_regwrite/wb_valid; outputs: raw1, raw2).

Verification
REQ-029 Reset mid-MUL_WAIT (mul issued, rst_n low cycle 3) -> all outputs 0 next sample, state RUN, no late mul_start.
REQ-030 addi x5,x0,7 then add x6,x5,x5 -> with PIPE_FWD_EN fwd_rs1=fwd_rs2=1, no stall; without, exactly one stall cycle.
REQ-031 mul x7,x1,x2, mul_done after 4 cycles -> mul_start 1 cycle, stall=1 for 4 cycles, wb_rd=7 wb_regwrite=1 following cycle.
REQ-032 csrrw x0,csr,x3 -> gpio_we=1 one cycle in WB, wb_regwrite=0.
REQ-033 Word 0x0000007F -> illegal pulse 1 cycle, wb_regwrite=0, gpio_we=0.
REQ-034 addi x0,x0,1 then add x1,x0,x0 -> no RAW, fwd_*=0, no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, instruction classes and EX state encoding for the pipe_ctrl slice.
// Decode and operand-usage helpers live here so the top and hazard unit agree on them.
package pipe_pkg;

    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        CLS_ALU_I,
        CLS_ALU_R,
        CLS_MUL,
        CLS_LUI,
        CLS_CSR,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic {
        ST_RUN,
        ST_MUL_WAIT
    } ex_state_e;

    function automatic instr_class_e decode_class(input logic [31:0] instr);
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        instr_class_e cls;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        cls    = CLS_ILLEGAL;
        case (opcode)
            OP_ALU_I: begin
                if (funct3 == F3_ADD || funct3 == F3_AND ||
                    (funct3 == F3_SLL && funct7 == F7_BASE))
                    cls = CLS_ALU_I;
            end
            OP_ALU_R: begin
                if (funct7 == F7_MULDIV && funct3 == F3_ADD)
                    cls = CLS_MUL;
                else if (funct7 == F7_BASE && (funct3 == F3_ADD || funct3 == F3_SLL ||
                                               funct3 == F3_SLT || funct3 == F3_AND))
                    cls = CLS_ALU_R;
                else if (funct7 == F7_SUB && funct3 == F3_ADD)
                    cls = CLS_ALU_R;
            end
            OP_LUI:    cls = CLS_LUI;
            OP_SYSTEM: if (funct3 == F3_CSRRW) cls = CLS_CSR;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // lui reads no register; only R-type (including mul) reads rs2
    function automatic logic uses_rs1(input instr_class_e cls);
        return (cls == CLS_ALU_I) || (cls == CLS_ALU_R) || (cls == CLS_MUL) || (cls == CLS_CSR);
    endfunction

    function automatic logic uses_rs2(input instr_class_e cls);
        return (cls == CLS_ALU_R) || (cls == CLS_MUL);
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Combinational read-after-write detection between the EX operands and the WB destination.
module pipe_hazard
    import pipe_pkg::*;
(
    input  logic         ex_valid,
    input  logic [4:0]   ex_rs1,
    input  logic [4:0]   ex_rs2,
    input  instr_class_e ex_class,
    input  logic [4:0]   wb_rd,
    input  logic         wb_regwrite,
    input  logic         wb_valid,
    output logic         raw1,
    output logic         raw2
);

    logic       wb_live;
    logic [1:0] src_used;
    logic [4:0] src_reg [2];
    logic [1:0] raw;

    assign wb_live     = ex_valid && wb_valid && wb_regwrite && (wb_rd != 5'd0);
    assign src_used[0] = uses_rs1(ex_class);
    assign src_used[1] = uses_rs2(ex_class);
    assign src_reg[0]  = ex_rs1;
    assign src_reg[1]  = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign raw[gi] = wb_live && src_used[gi] && (src_reg[gi] == wb_rd);
        end
    endgenerate

    assign raw1 = raw[0];
    assign raw2 = raw[1];

endmodule

// File: rtl/pipe_ctrl.sv
// EX/WB control for a 3-stage RV32 subset pipeline with multi-cycle multiply handshake.
// Define PIPE_FWD_EN to resolve RAW hazards by WB forwarding instead of a one-cycle stall.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic        mul_done,
    output logic        stall,
    output logic [31:0] ex_instr,
    output logic        ex_valid,
    output logic        mul_start,
    output logic        fwd_rs1,
    output logic        fwd_rs2,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        gpio_we,
    output logic        illegal
);

    ex_state_e    state_reg, state_next;
    logic         ex_valid_reg;
    logic [31:0]  ex_instr_reg;
    instr_class_e ex_class_reg;
    logic         wb_valid_reg;
    logic [4:0]   wb_rd_reg;
    logic         wb_regwrite_reg;
    logic         wb_csr_reg;
    logic         raw1, raw2, raw_stall, ex_retire;

    pipe_hazard u_hazard (
        .ex_valid    (ex_valid_reg),
        .ex_rs1      (ex_instr_reg[19:15]),
        .ex_rs2      (ex_instr_reg[24:20]),
        .ex_class    (ex_class_reg),
        .wb_rd       (wb_rd_reg),
        .wb_regwrite (wb_regwrite_reg),
        .wb_valid    (wb_valid_reg),
        .raw1        (raw1),
        .raw2        (raw2)
    );

`ifdef PIPE_FWD_EN
    assign raw_stall = 1'b0;
    assign fwd_rs1   = raw1;
    assign fwd_rs2   = raw2;
`else
    assign raw_stall = raw1 || raw2;
    assign fwd_rs1   = 1'b0;
    assign fwd_rs2   = 1'b0;
`endif

    // A mul waiting on a RAW stall only starts once its operands are resolved
    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (ex_valid_reg) begin
                    if (raw_stall) begin
                        stall = 1'b1;
                    end else if (ex_class_reg == CLS_MUL) begin
                        mul_start  = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) state_next = ST_RUN;
                else          stall      = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign ex_retire = ex_valid_reg && (ex_class_reg != CLS_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            ex_valid_reg    <= 1'b0;
            ex_instr_reg    <= '0;
            ex_class_reg    <= CLS_ALU_I;
            wb_valid_reg    <= 1'b0;
            wb_rd_reg       <= '0;
            wb_regwrite_reg <= 1'b0;
            wb_csr_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (!stall) begin
                ex_valid_reg    <= instr_valid;
                ex_instr_reg    <= instr_valid ? instr_in : '0;
                ex_class_reg    <= decode_class(instr_in);
                wb_valid_reg    <= ex_retire;
                wb_rd_reg       <= ex_retire ? ex_instr_reg[11:7] : 5'd0;
                wb_regwrite_reg <= ex_retire && (ex_instr_reg[11:7] != 5'd0);
                wb_csr_reg      <= ex_retire && (ex_class_reg == CLS_CSR);
            end else begin
                wb_valid_reg    <= 1'b0;
                wb_rd_reg       <= '0;
                wb_regwrite_reg <= 1'b0;
                wb_csr_reg      <= 1'b0;
            end
        end
    end

    assign ex_instr    = ex_instr_reg;
    assign ex_valid    = ex_valid_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_regwrite = wb_regwrite_reg;
    assign gpio_we     = wb_valid_reg && wb_csr_reg;
    assign illegal     = ex_valid_reg && (ex_class_reg == CLS_ILLEGAL);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard/mul/csr/illegal/reset cases plus random traffic.
module tb_pipe_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic        mul_done = 1'b0;
    logic        stall, ex_valid, mul_start, fwd_rs1, fwd_rs2;
    logic        wb_valid, wb_regwrite, gpio_we, illegal;
    logic [31:0] ex_instr;
    logic [4:0]  wb_rd;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .mul_done    (mul_done),
        .stall       (stall),
        .ex_instr    (ex_instr),
        .ex_valid    (ex_valid),
        .mul_start   (mul_start),
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .gpio_we     (gpio_we),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        ill;
        logic [4:0]  rd;
        logic        rw;
        logic        gpio;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, n_stall = 0, n_mul_start = 0, n_fwd1 = 0, n_fwd2 = 0;
    int   n_gpio = 0, n_illegal = 0, n_rw = 0, last_done_cyc = -1, last_wb_cyc = -1;
    int   mul_delay = 4, exp_muls = 0;
    bit   rand_done_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: an instruction is legal iff it matches one of the listed encodings
    function automatic exp_t ref_expect(input logic [31:0] w);
        logic [31:0] mask  [11];
        logic [31:0] match [11];
        exp_t e;
        bit legal;
        mask  = '{32'h0000707F, 32'h0000707F, 32'hFE00707F,
                  32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                  32'hFE00707F, 32'h0000007F, 32'h0000707F};
        match = '{32'h00000013, 32'h00007013, 32'h00001013,
                  32'h00000033, 32'h40000033, 32'h00007033, 32'h00001033, 32'h00002033,
                  32'h02000033, 32'h00000037, 32'h00001073};
        legal = 1'b0;
        for (int i = 0; i < 11; i++)
            if ((w & mask[i]) == match[i]) legal = 1'b1;
        e.word = w;
        e.ill  = !legal;
        e.rd   = legal ? w[11:7] : 5'd0;
        e.rw   = legal && (w[11:7] != 5'd0);
        e.gpio = legal && ((w & 32'h0000707F) == 32'h00001073);
        return e;
    endfunction

    function automatic bit is_mul(input logic [31:0] w);
        return (w & 32'hFE00707F) == 32'h02000033;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [2:0]  r_f3 [3];
        logic [31:0] w;
        r_f3 = '{3'b001, 3'b010, 3'b111};
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        f3  = r_f3[$urandom_range(0, 2)];
        case ($urandom_range(0, 9))
            0:       w = {12'($urandom), rs1, 3'b000, rd, 7'h13};
            1:       w = {12'($urandom), rs1, 3'b111, rd, 7'h13};
            2:       w = {7'h00, 5'($urandom), rs1, 3'b001, rd, 7'h13};
            3:       w = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            4:       w = {7'h00, rs2, rs1, f3, rd, 7'h33};
            5:       w = {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
            6:       w = {20'($urandom), rd, 7'h37};
            7:       w = {12'h7C0, rs1, 3'b001, rd, 7'h73};
            8:       w = $urandom;
            default: w = ($urandom_range(0, 1) != 0) ? {12'($urandom), rs1, 3'b110, rd, 7'h13}
                                                     : {7'h01, rs2, rs1, 3'b001, rd, 7'h33};
        endcase
        return w;
    endfunction

    task automatic clear_counts();
        n_stall = 0; n_mul_start = 0; n_fwd1 = 0; n_fwd2 = 0;
        n_gpio = 0; n_illegal = 0; n_rw = 0; last_done_cyc = -1; last_wb_cyc = -1;
    endtask

    // Called at a falling edge; returns at the falling edge after the word is captured
    task automatic issue(input logic [31:0] w, output int waits);
        bit ok;
        waits = 0;
        ok = 1'b0;
        instr_in = w;
        instr_valid = 1'b1;
        while (waits <= 60) begin
            #4;
            if (!stall) begin ok = 1'b1; break; end
            @(negedge clk);
            waits++;
        end
        if (ok) begin
            exp_q.push_back(ref_expect(w));
            if (is_mul(w)) exp_muls++;
        end else begin
            check("issue_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in = '0;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {23'd0, stall, mul_start, fwd_rs1, fwd_rs2, wb_valid,
                               wb_regwrite, gpio_we, illegal, ex_valid}, 32'd0);
        check({name, "_ex_instr"}, ex_instr, 32'd0);
        check({name, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    endtask

    // Multiplier stand-in: mul_done pulses mul_delay cycles after the start pulse
    initial begin : mul_drv
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mul_done = 1'b1;
            end else if (rand_done_en && !mul_start && $urandom_range(0, 7) == 0) begin
                mul_done = 1'b1;
            end
            if (mul_start) cnt = mul_delay;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) continue;
            if (stall)       n_stall++;
            if (mul_start)   n_mul_start++;
            if (fwd_rs1)     n_fwd1++;
            if (fwd_rs2)     n_fwd2++;
            if (gpio_we)     n_gpio++;
            if (illegal)     n_illegal++;
            if (wb_regwrite) n_rw++;
            if (mul_done)    last_done_cyc = cyc;
            if (gpio_we && !wb_valid) check("gpio_without_wb", 32'd1, 32'd0);
            if (wb_valid) begin
                last_wb_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("wb_retire[%h]", e.word),
                          {24'd0, 1'b0, wb_rd, wb_regwrite, gpio_we},
                          {24'd0, e.ill, e.rd, e.rw, e.gpio});
                end
            end
            if (illegal) begin
                if (exp_q.size() == 0) begin
                    check("illegal_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("illegal_retire[%h]", e.word), {31'd0, e.ill}, 32'd1);
                end
            end
        end
    end

    initial begin : stim
        int w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // addi x5,x0,7 accepted on the first edge after reset, then add x6,x5,x5
        clear_counts();
        issue(32'h00700293, w);
        check("first_accept_waits", w, 32'd0);
        check("first_ex_instr", ex_instr, 32'h00700293);
        check("first_ex_valid", {31'd0, ex_valid}, 32'd1);
        issue(32'h00528333, w);
        idle(6);
        check("raw_stall_cycles", n_stall, FWD ? 32'd0 : 32'd1);
        check("raw_fwd_rs1", n_fwd1, FWD ? 32'd1 : 32'd0);
        check("raw_fwd_rs2", n_fwd2, FWD ? 32'd1 : 32'd0);

        // x0 destination never creates a hazard
        clear_counts();
        issue(32'h00100013, w);
        issue(32'h000000B3, w);
        idle(6);
        check("x0_stall_cycles", n_stall, 32'd0);
        check("x0_fwd", n_fwd1 + n_fwd2, 32'd0);

        // mul x7,x1,x2 with completion 4 cycles after start
        mul_delay = 4;
        clear_counts();
        issue(32'h022083B3, w);
        idle(10);
        check("mul_start_pulses", n_mul_start, 32'd1);
        check("mul_stall_cycles", n_stall, 32'd4);
        check("mul_wb_after_done", last_wb_cyc, last_done_cyc + 1);

        // csrrw x0,0x7c0,x3
        clear_counts();
        issue(32'h7C019073, w);
        idle(5);
        check("csr_gpio_cycles", n_gpio, 32'd1);
        check("csr_regwrite_cycles", n_rw, 32'd0);

        // illegal opcode
        clear_counts();
        issue(32'h0000007F, w);
        idle(5);
        check("illegal_cycles", n_illegal, 32'd1);
        check("illegal_gpio_cycles", n_gpio, 32'd0);
        check("illegal_regwrite_cycles", n_rw, 32'd0);

        // reset asserted while the multiplier is busy
        mul_delay = 8;
        clear_counts();
        issue(32'h022083B3, w);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_mul");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        idle(12);
        check("post_reset_mul_start", n_mul_start, 32'd0);
        check("post_reset_stall", n_stall, 32'd0);

        // random traffic with spurious mul_done pulses while running
        rand_done_en = 1'b1;
        exp_muls = 0;
        clear_counts();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                mul_delay = $urandom_range(1, 5);
                issue(rand_instr(), w);
            end
        end
        idle(20);
        check("rand_mul_starts", n_mul_start, exp_muls);
        check("rand_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
